// File: rtl/ofdm_tx_qam_mapper.sv
`default_nettype none
// ============================================================================
// Module   : ofdm_tx_qam_mapper
// Purpose  : Packs serial bits into Gray-coded 16-QAM I/Q samples, indexed per frame.
// Revision : 1.0 - initial release
// ============================================================================
module ofdm_tx_qam_mapper #(
    parameter int IQ_W           = 16,
    parameter int SCALE          = 2048,
    parameter int SYMS_PER_FRAME = 56
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   clear,
    input  logic                   din,
    input  logic                   din_valid,
    output logic                   din_rready,
    output logic signed [IQ_W-1:0] i_out,
    output logic signed [IQ_W-1:0] q_out,
    output logic [5:0]             sym_idx,
    output logic                   frame_last,
    output logic                   dout_valid,
    input  logic                   dout_rready
);

    localparam logic signed [IQ_W-1:0] LVL1     = IQ_W'(SCALE);
    localparam logic signed [IQ_W-1:0] LVL3     = IQ_W'(3 * SCALE);
    localparam logic [5:0]             LAST_SYM = 6'(SYMS_PER_FRAME - 1);
    localparam logic [2:0]             FULL_CNT = 3'd4;

    logic [3:0]             acc_q, acc_d;
    logic [2:0]             acc_cnt_q, acc_cnt_d;
    logic [5:0]             sym_cnt_q, sym_cnt_d;
    logic                   din_rready_q, din_rready_d;
    logic                   dout_valid_q, dout_valid_d;
    logic signed [IQ_W-1:0] i_q, i_d;
    logic signed [IQ_W-1:0] q_q, q_d;
    logic [5:0]             sym_idx_q, sym_idx_d;
    logic                   frame_last_q, frame_last_d;

    logic w_accept;
    logic w_xfer;

    // Gray pair to amplitude: adjacent levels differ in exactly one bit.
    function automatic logic signed [IQ_W-1:0] gray_level(input logic [1:0] pair);
        case (pair)
            2'b00:   gray_level = -LVL3;
            2'b01:   gray_level = -LVL1;
            2'b11:   gray_level = LVL1;
            default: gray_level = LVL3;
        endcase
    endfunction

    assign w_accept = din_valid && din_rready_q;
    assign w_xfer   = (acc_cnt_q == FULL_CNT) && (!dout_valid_q || dout_rready);

    always_comb begin
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        sym_cnt_d    = sym_cnt_q;
        dout_valid_d = dout_valid_q;
        i_d          = i_q;
        q_d          = q_q;
        sym_idx_d    = sym_idx_q;
        frame_last_d = frame_last_q;

        if (clear) begin
            acc_d        = '0;
            acc_cnt_d    = '0;
            sym_cnt_d    = '0;
            dout_valid_d = 1'b0;
            i_d          = '0;
            q_d          = '0;
            sym_idx_d    = '0;
            frame_last_d = 1'b0;
        end else begin
            if (dout_valid_q && dout_rready) begin
                dout_valid_d = 1'b0;
            end
            // A transfer overrides the drain above so back-to-back symbols have no bubble.
            if (w_xfer) begin
                i_d          = gray_level(acc_q[3:2]);
                q_d          = gray_level(acc_q[1:0]);
                sym_idx_d    = sym_cnt_q;
                frame_last_d = (sym_cnt_q == LAST_SYM);
                dout_valid_d = 1'b1;
                acc_cnt_d    = '0;
                sym_cnt_d    = (sym_cnt_q == LAST_SYM) ? 6'd0 : sym_cnt_q + 6'd1;
            end else if (w_accept) begin
                acc_d     = {acc_q[2:0], din};
                acc_cnt_d = acc_cnt_q + 3'd1;
            end
        end

        din_rready_d = (acc_cnt_d != FULL_CNT) && !clear;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            sym_cnt_q    <= '0;
            din_rready_q <= 1'b0;
            dout_valid_q <= 1'b0;
            i_q          <= '0;
            q_q          <= '0;
            sym_idx_q    <= '0;
            frame_last_q <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            sym_cnt_q    <= sym_cnt_d;
            din_rready_q <= din_rready_d;
            dout_valid_q <= dout_valid_d;
            i_q          <= i_d;
            q_q          <= q_d;
            sym_idx_q    <= sym_idx_d;
            frame_last_q <= frame_last_d;
        end
    end

    assign din_rready = din_rready_q;
    assign dout_valid = dout_valid_q;
    assign i_out      = i_q;
    assign q_out      = q_q;
    assign sym_idx    = sym_idx_q;
    assign frame_last = frame_last_q;

endmodule
`default_nettype wire

// File: doc/ofdm_tx_qam_mapper.md
Name: ofdm_tx_qam_mapper

Overview:
- Downstream neighbour of the OFDM Tx input bit buffer. Consumes its serial bit stream over a valid/ready handshake.
- Packs every 4 bits into a Gray-coded 16-QAM symbol and emits signed I/Q samples, one symbol per handshake.
- Tags each symbol with its subcarrier index within the 224-bit frame (56 symbols) and flags the last one, ready for the IFFT loader.

Parameters:
- IQ_W, 16, width of signed I and Q outputs (two's complement).
- SCALE, 2048, amplitude of the unit constellation level; 3*SCALE must be < 2^(IQ_W-1).
- SYMS_PER_FRAME, 56, symbols per frame (224 bits / 4).

Ports:
- clk  in  1  single clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- clear  in  1  synchronous flush of the accumulator, symbol counter and output register.
- din  in  1  serial data bit from the input buffer.
- din_valid  in  1  din is valid.
- din_rready  out  1  mapper accepts a bit this cycle.
- i_out  out  IQ_W  in-phase sample, signed.
- q_out  out  IQ_W  quadrature sample, signed.
- sym_idx  out  6  subcarrier index of the current output symbol, 0..SYMS_PER_FRAME-1.
- frame_last  out  1  current output symbol is index SYMS_PER_FRAME-1.
- dout_valid  out  1  output symbol is valid.
- dout_rready  in  1  downstream accepts the symbol.

Behaviour:
- Reset: async on nreset low. All registers clear immediately: acc=0, acc_cnt=0, sym_cnt=0, din_rready=0, dout_valid=0, i_out=0, q_out=0, sym_idx=0, frame_last=0. din_rready rises on the first clock edge after nreset deasserts.
- Bit accept: a bit is accepted when din_valid && din_rready.
  - acc shifts left; the new bit enters the LSB.
  - acc_cnt increments 0→4.
  - The first bit received is symbol bit b3 (MSB).
- din_rready is registered: din_rready <= (acc_cnt_next != 4) && !clear.
  - It drops in the cycle after the 4th bit is accepted.
  - It stays low while a full symbol waits.
- Transfer:
  - Condition: acc_cnt==4 && (!dout_valid || dout_rready).
  - Action: register the mapped I/Q, set sym_idx=sym_cnt, set frame_last=(sym_cnt==SYMS_PER_FRAME-1), set dout_valid=1, set acc_cnt=0.
  - sym_cnt increments and wraps SYMS_PER_FRAME-1→0.
  - No bit is accepted in the transfer cycle (din_rready=0). din_rready returns to 1 on the next cycle.
- Steady-state throughput: 1 symbol per 5 cycles.
- Output latency: dout_valid asserts 2 cycles after the edge that accepts the 4th bit (cycle N accept, N+1 transfer, N+2 visible).
- Output handshake:
  - dout_valid clears on dout_valid && dout_rready unless a transfer occurs in the same cycle. In that case the new symbol replaces the old one with no bubble.
  - While dout_valid && !dout_rready, i_out/q_out/sym_idx/frame_last hold stable.
- Mapping, per 2-bit Gray pair (I from b3b2, Q from b1b0):
  - 00 → -3*SCALE
  - 01 → -1*SCALE
  - 11 → +1*SCALE
  - 10 → +3*SCALE
  - Computed at full IQ_W width; no saturation needed given the parameter constraint.
- clear (synchronous) takes priority over accept and transfer.
  - acc_cnt=0, sym_cnt=0, dout_valid=0, din_rready=0 next cycle, then 1.
  - Partial symbols are discarded.
- Reset mid-operation: an in-flight partial symbol and any pending output are lost. Numbering restarts at sym_idx 0.
- din_valid while din_rready=0: ignored; upstream must hold the bit.
- No frame sync input: symbol numbering counts from reset/clear. Upstream delivers whole 224-bit frames.

Test Plan:
- Reset, then bits 1,0,1,1 with din_valid=1 and dout_rready=1 → one symbol: i_out=+6144 (0x1800), q_out=+2048 (0x0800), sym_idx=0, frame_last=0. dout_valid is high 2 cycles after the 4th accept, for exactly 1 cycle.
- Bits 0,0,0,1 → i_out=-6144 (0xE800), q_out=-2048 (0xF800). All 16 nibble values map per the Gray table.
- dout_rready=0 after first symbol, continuous bits → 4 more bits accepted, then din_rready=0 and outputs hold. Raising dout_rready → old symbol consumed; new symbol appears the next cycle with no bubble.
- 224 continuous bits, dout_rready=1 → 56 symbols, sym_idx 0..55. frame_last=1 only on idx 55. The 57th symbol has sym_idx=0.
- 2 bits sent, then clear pulsed → dout_valid stays 0. The next 4 bits produce sym_idx=0 with values from those 4 bits only.
- nreset asserted asynchronously mid-symbol with dout_valid=1 → all outputs 0 immediately. din_rready=1 one edge after release; the first subsequent symbol has sym_idx=0.
